axi_addr_arb: RTL and testbench

//  N-way round-robin arbiter/scheduler sharing one AXI address channel between N address-translation FIFOs.

---
 rtl/axi_addr_pkg.sv | 35 +++
 rtl/axi_rr_arb.sv | 32 +++
 rtl/axi_addr_arb.sv | 113 +++++++++++
 tb/tb_axi_addr_arb.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_addr_pkg.sv
// Shared entry layout, FSM encoding and transaction-log packing for the AXI address arbiter.
package axi_addr_pkg;

  localparam int unsigned ENTRY_W  = 97;
  localparam int unsigned ADDR_LSB = 0;
  localparam int unsigned ADDR_MSB = 63;
  localparam int unsigned LEN_LSB  = 64;
  localparam int unsigned LEN_MSB  = 66;
  localparam int unsigned SIZE_LSB = 67;
  localparam int unsigned SIZE_MSB = 69;
  localparam int unsigned ID_LSB   = 70;
  localparam int unsigned ID_MSB   = 77;

  typedef struct packed {
    logic [ENTRY_W-2-ID_MSB:0]   rsvd;
    logic [ID_MSB-ID_LSB:0]     id;
    logic [SIZE_MSB-SIZE_LSB:0] size;
    logic [LEN_MSB-LEN_LSB:0]   len;
    logic [ADDR_MSB-ADDR_LSB:0] addr;
  } addr_entry_t;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } arb_state_t;

  // Log word is the entry with the reserved field forced to zero.
  function automatic addr_entry_t pack_transfifo(input addr_entry_t e);
    addr_entry_t r;
    r      = e;
    r.rsvd = '0;
    return r;
  endfunction

endpackage

// File: rtl/axi_rr_arb.sv
// N-way rotating-priority arbiter: first requester at or after ptr wins.
module axi_rr_arb #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] idx
);

  localparam int unsigned IW = $clog2(N);

  // Scan from farthest to nearest offset so the nearest requester overwrites last.
  always_comb begin : pick
    logic [IW-1:0] cand;
    int unsigned   off;
    grant = '0;
    idx   = '0;
    cand  = '0;
    off   = 0;
    for (int unsigned k = 0; k < N; k++) begin
      off  = N - 1 - k;
      cand = IW'((32'(ptr) + off) % N);
      if (req[cand]) begin
        grant       = '0;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/axi_addr_arb.sv
// Round-robin scheduler sharing one AXI address channel among NREQ addrtrans FIFOs,
// with outstanding-credit limit. Optional priority arbitration via AXI_ARB_QOS_EN.
module axi_addr_arb #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned MAX_OUTST = 16,
  parameter int unsigned ENTRY_W   = 97
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NREQ-1:0]           req_fifo_empty,
  input  logic [NREQ*ENTRY_W-1:0]   req_mem_rddata,
  output logic [NREQ-1:0]           req_mem_rd,
  input  logic [NREQ-1:0]           req_hipri,
  input  logic                      axi_axready,
  output logic                      axi_axvalid,
  output logic [7:0]                axi_aid,
  output logic [63:0]               axi_addr,
  output logic [2:0]                axi_alen,
  output logic [2:0]                axi_asize,
  input  logic                      rd_transfifo_full,
  output logic                      rd_transfifo_wr,
  output logic [96:0]               io_transfifo_wrdata,
  input  logic                      resp_done,
  output logic [$clog2(NREQ)-1:0]   grant_idx,
  output logic [7:0]                outst_cnt,
  output logic                      err_underflow
);
  import axi_addr_pkg::*;

  localparam int unsigned IW = $clog2(NREQ);

  arb_state_t      state, state_next;
  addr_entry_t     payload;
  logic [IW-1:0]   rr_ptr, win_idx;
  logic [NREQ-1:0] nonempty, win_oh;
  logic            handshake, can_arb, eligible, arb_fire;
  logic [8:0]      cnt_post;

  assign nonempty  = ~req_fifo_empty;
  assign handshake = (state == ISSUE) && axi_axready;
  // Credit check sees the count as it will be after this cycle's handshake.
  assign cnt_post  = {1'b0, outst_cnt} + {8'd0, handshake};
  assign eligible  = (|nonempty) && (cnt_post < 9'(MAX_OUTST)) && !rd_transfifo_full;
  assign can_arb   = reset_n && ((state == IDLE) || handshake);
  assign arb_fire  = can_arb && eligible;

`ifdef AXI_ARB_QOS_EN
  logic [NREQ-1:0] hi_req, hi_oh, lo_oh;
  logic [IW-1:0]   hi_idx, lo_idx;

  assign hi_req = nonempty & req_hipri;

  axi_rr_arb #(.N(NREQ)) u_arb_hi (.req(hi_req),   .ptr(rr_ptr), .grant(hi_oh), .idx(hi_idx));
  axi_rr_arb #(.N(NREQ)) u_arb_lo (.req(nonempty), .ptr(rr_ptr), .grant(lo_oh), .idx(lo_idx));

  assign win_oh  = (|hi_req) ? hi_oh  : lo_oh;
  assign win_idx = (|hi_req) ? hi_idx : lo_idx;
`else
  logic unused_hipri;
  assign unused_hipri = ^req_hipri;

  axi_rr_arb #(.N(NREQ)) u_arb (.req(nonempty), .ptr(rr_ptr), .grant(win_oh), .idx(win_idx));
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (arb_fire)       state_next = ISSUE;
    else if (handshake) state_next = IDLE;
  end

  always_comb begin
    axi_axvalid         = (state == ISSUE);
    rd_transfifo_wr     = handshake;
    req_mem_rd          = arb_fire ? win_oh : '0;
    axi_aid             = payload.id;
    axi_addr            = payload.addr;
    axi_alen            = payload.len;
    axi_asize           = payload.size;
    io_transfifo_wrdata = pack_transfifo(payload);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      payload   <= '0;
      grant_idx <= '0;
      rr_ptr    <= '0;
    end else if (arb_fire) begin
      payload   <= addr_entry_t'(req_mem_rddata[32'(win_idx)*ENTRY_W +: ENTRY_W]);
      grant_idx <= win_idx;
      rr_ptr    <= (win_idx == IW'(NREQ - 1)) ? '0 : win_idx + IW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      outst_cnt     <= '0;
      err_underflow <= 1'b0;
    end else begin
      if (handshake && !(resp_done && outst_cnt != '0))
        outst_cnt <= outst_cnt + 8'd1;
      else if (!handshake && resp_done && outst_cnt != '0)
        outst_cnt <= outst_cnt - 8'd1;
      if (resp_done && outst_cnt == '0)
        err_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axi_addr_arb.sv
// Directed bench for axi_addr_arb: main instance (MAX_OUTST=16) plus a credit-limited one (MAX_OUTST=2).
module tb_axi_addr_arb;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [3:0]   req_fifo_empty;
  logic [3:0]   req_hipri;
  logic         axi_axready, rd_transfifo_full, resp_done;
  logic [96:0]  ent [4];
  logic [387:0] req_mem_rddata;

  logic [3:0]  rd_m, rd_c;
  logic        valid_m, valid_c, wr_m, wr_c, err_m, err_c;
  logic [7:0]  aid_m, aid_c, outst_m, outst_c;
  logic [63:0] addr_m, addr_c;
  logic [2:0]  len_m, len_c, size_m, size_c;
  logic [96:0] wrdata_m, wrdata_c;
  logic [1:0]  gidx_m, gidx_c;

  logic        sel_c;
  logic [3:0]  pop_src;
  int unsigned push [4];
  int unsigned pop  [4];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  assign req_mem_rddata = {ent[3], ent[2], ent[1], ent[0]};
  assign pop_src        = sel_c ? rd_c : rd_m;

  always_comb begin
    for (int i = 0; i < 4; i++) req_fifo_empty[i] = (push[i] == pop[i]);
  end

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (pop_src[i]) pop[i] <= pop[i] + 1;
  end

  axi_addr_arb #(.NREQ(4), .MAX_OUTST(16), .ENTRY_W(97)) dut (
    .clk(clk), .reset_n(reset_n), .req_fifo_empty(req_fifo_empty), .req_mem_rddata(req_mem_rddata),
    .req_mem_rd(rd_m), .req_hipri(req_hipri), .axi_axready(axi_axready), .axi_axvalid(valid_m),
    .axi_aid(aid_m), .axi_addr(addr_m), .axi_alen(len_m), .axi_asize(size_m),
    .rd_transfifo_full(rd_transfifo_full), .rd_transfifo_wr(wr_m), .io_transfifo_wrdata(wrdata_m),
    .resp_done(resp_done), .grant_idx(gidx_m), .outst_cnt(outst_m), .err_underflow(err_m)
  );

  axi_addr_arb #(.NREQ(4), .MAX_OUTST(2), .ENTRY_W(97)) dut_c (
    .clk(clk), .reset_n(reset_n), .req_fifo_empty(req_fifo_empty), .req_mem_rddata(req_mem_rddata),
    .req_mem_rd(rd_c), .req_hipri(req_hipri), .axi_axready(axi_axready), .axi_axvalid(valid_c),
    .axi_aid(aid_c), .axi_addr(addr_c), .axi_alen(len_c), .axi_asize(size_c),
    .rd_transfifo_full(rd_transfifo_full), .rd_transfifo_wr(wr_c), .io_transfifo_wrdata(wrdata_c),
    .resp_done(resp_done), .grant_idx(gidx_c), .outst_cnt(outst_c), .err_underflow(err_c)
  );

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; axi_axready = 1'b0; resp_done = 1'b0; rd_transfifo_full = 1'b0; req_hipri = '0;
    step();
    for (int i = 0; i < 4; i++) push[i] = pop[i];
    step();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step(); step();
    checks++; if (valid_m !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", valid_m); end
    checks++; if (rd_m !== 4'b0) begin errors++; $display("FAIL reset_rd got %b want 0000", rd_m); end
    checks++; if (wr_m !== 1'b0) begin errors++; $display("FAIL reset_wr got %0b want 0", wr_m); end
    checks++; if (outst_m !== 8'd0) begin errors++; $display("FAIL reset_outst got %0d want 0", outst_m); end
    checks++; if (err_m !== 1'b0) begin errors++; $display("FAIL reset_err got %0b want 0", err_m); end
    checks++; if (gidx_m !== 2'd0) begin errors++; $display("FAIL reset_gidx got %0d want 0", gidx_m); end
    checks++; if (addr_m !== 64'd0) begin errors++; $display("FAIL reset_addr got %0h want 0", addr_m); end
    reset_n = 1'b1;
  endtask

  task automatic test_single();
    logic [96:0] exp_w;
    do_reset();
    ent[1] = {19'h7FFFF, 8'h5A, 3'd2, 3'd3, 64'h1000};
    exp_w  = {19'd0, 8'h5A, 3'd2, 3'd3, 64'h1000};
    axi_axready = 1'b1;
    push[1] = push[1] + 1;
    #1;
    checks++; if (rd_m !== 4'b0010) begin errors++; $display("FAIL single_pop got %b want 0010", rd_m); end
    step();
    checks++; if (valid_m !== 1'b1) begin errors++; $display("FAIL single_valid got %0b want 1", valid_m); end
    checks++; if (wr_m !== 1'b1) begin errors++; $display("FAIL single_wr got %0b want 1", wr_m); end
    checks++; if (gidx_m !== 2'd1) begin errors++; $display("FAIL single_gidx got %0d want 1", gidx_m); end
    checks++; if (wrdata_m !== exp_w) begin errors++; $display("FAIL single_wrdata got %h want %h", wrdata_m, exp_w); end
    checks++; if ({aid_m, size_m, len_m, addr_m} !== exp_w[77:0])
      begin errors++; $display("FAIL single_fields got %h want %h", {aid_m, size_m, len_m, addr_m}, exp_w[77:0]); end
    checks++; if (rd_m !== 4'b0) begin errors++; $display("FAIL single_nopop got %b want 0000", rd_m); end
    step();
    checks++; if (valid_m !== 1'b0) begin errors++; $display("FAIL single_idle got %0b want 0", valid_m); end
    checks++; if (outst_m !== 8'd1) begin errors++; $display("FAIL single_outst got %0d want 1", outst_m); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_rd;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      ent[i] = {19'd0, 8'(i), 3'd1, 3'd0, 64'hA000 + 64'(i * 16)};
      push[i] = push[i] + 2;
    end
    axi_axready = 1'b1;
    #1;
    checks++; if (rd_m !== 4'b0001) begin errors++; $display("FAIL rr_first_pop got %b want 0001", rd_m); end
    for (int k = 0; k < 5; k++) begin
      step();
      exp_rd = 4'b0001 << ((k + 1) % 4);
      checks++; if (valid_m !== 1'b1) begin errors++; $display("FAIL rr_valid[%0d] got %0b want 1", k, valid_m); end
      checks++; if (gidx_m !== 2'(k % 4)) begin errors++; $display("FAIL rr_gidx[%0d] got %0d want %0d", k, gidx_m, k % 4); end
      checks++; if (addr_m !== 64'hA000 + 64'((k % 4) * 16))
        begin errors++; $display("FAIL rr_addr[%0d] got %0h want %0h", k, addr_m, 64'hA000 + 64'((k % 4) * 16)); end
      checks++; if (rd_m !== exp_rd) begin errors++; $display("FAIL rr_pop[%0d] got %b want %b", k, rd_m, exp_rd); end
      checks++; if (outst_m !== 8'(k)) begin errors++; $display("FAIL rr_outst[%0d] got %0d want %0d", k, outst_m, k); end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    ent[2] = {19'd0, 8'h33, 3'd3, 3'd7, 64'hDEAD_BEEF_0000_0040};
    push[2] = push[2] + 1;
    #1;
    checks++; if (rd_m !== 4'b0100) begin errors++; $display("FAIL bp_pop got %b want 0100", rd_m); end
    for (int k = 0; k < 5; k++) begin
      step();
      checks++; if (valid_m !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got %0b want 1", k, valid_m); end
      checks++; if (gidx_m !== 2'd2) begin errors++; $display("FAIL bp_gidx[%0d] got %0d want 2", k, gidx_m); end
      checks++; if (addr_m !== 64'hDEAD_BEEF_0000_0040) begin errors++; $display("FAIL bp_addr[%0d] got %0h want deadbeef00000040", k, addr_m); end
      checks++; if (rd_m !== 4'b0) begin errors++; $display("FAIL bp_nopop[%0d] got %b want 0000", k, rd_m); end
      checks++; if (wr_m !== 1'b0) begin errors++; $display("FAIL bp_nowr[%0d] got %0b want 0", k, wr_m); end
    end
    axi_axready = 1'b1;
    #1;
    checks++; if (wr_m !== 1'b1) begin errors++; $display("FAIL bp_wr got %0b want 1", wr_m); end
    step();
    checks++; if (wr_m !== 1'b0) begin errors++; $display("FAIL bp_single_wr got %0b want 0", wr_m); end
    checks++; if (valid_m !== 1'b0) begin errors++; $display("FAIL bp_idle got %0b want 0", valid_m); end
    checks++; if (outst_m !== 8'd1) begin errors++; $display("FAIL bp_outst got %0d want 1", outst_m); end
  endtask

  task automatic test_credit();
    sel_c = 1'b1;
    do_reset();
    ent[0] = {19'd0, 8'h01, 3'd0, 3'd0, 64'h40};
    axi_axready = 1'b1;
    push[0] = push[0] + 4;
    #1;
    checks++; if (rd_c !== 4'b0001) begin errors++; $display("FAIL cr_pop0 got %b want 0001", rd_c); end
    step();
    checks++; if (valid_c !== 1'b1) begin errors++; $display("FAIL cr_valid1 got %0b want 1", valid_c); end
    checks++; if (rd_c !== 4'b0001) begin errors++; $display("FAIL cr_pop1 got %b want 0001", rd_c); end
    step();
    checks++; if (outst_c !== 8'd1) begin errors++; $display("FAIL cr_outst1 got %0d want 1", outst_c); end
    checks++; if (rd_c !== 4'b0) begin errors++; $display("FAIL cr_nopop got %b want 0000", rd_c); end
    step();
    checks++; if (valid_c !== 1'b0) begin errors++; $display("FAIL cr_stall_valid got %0b want 0", valid_c); end
    checks++; if (outst_c !== 8'd2) begin errors++; $display("FAIL cr_outst2 got %0d want 2", outst_c); end
    checks++; if (req_fifo_empty[0] !== 1'b0) begin errors++; $display("FAIL cr_fifo_left got %0b want 0", req_fifo_empty[0]); end
    step();
    checks++; if (valid_c !== 1'b0) begin errors++; $display("FAIL cr_stall2 got %0b want 0", valid_c); end
    resp_done = 1'b1;
    #1;
    checks++; if (rd_c !== 4'b0) begin errors++; $display("FAIL cr_resp_nopop got %b want 0000", rd_c); end
    step();
    resp_done = 1'b0;
    #1;
    checks++; if (outst_c !== 8'd1) begin errors++; $display("FAIL cr_outst_dec got %0d want 1", outst_c); end
    checks++; if (rd_c !== 4'b0001) begin errors++; $display("FAIL cr_repop got %b want 0001", rd_c); end
    step();
    checks++; if (valid_c !== 1'b1) begin errors++; $display("FAIL cr_revalid got %0b want 1", valid_c); end
    resp_done = 1'b1;
    #1;
    checks++; if (wr_c !== 1'b1) begin errors++; $display("FAIL cr_wr got %0b want 1", wr_c); end
    step();
    resp_done = 1'b0;
    checks++; if (outst_c !== 8'd1) begin errors++; $display("FAIL cr_same_cycle got %0d want 1", outst_c); end
    checks++; if (err_c !== 1'b0) begin errors++; $display("FAIL cr_err got %0b want 0", err_c); end
    sel_c = 1'b0;
  endtask

  task automatic test_underflow_reset();
    do_reset();
    resp_done = 1'b1;
    step();
    resp_done = 1'b0;
    checks++; if (err_m !== 1'b1) begin errors++; $display("FAIL uf_err got %0b want 1", err_m); end
    checks++; if (outst_m !== 8'd0) begin errors++; $display("FAIL uf_outst got %0d want 0", outst_m); end
    step();
    checks++; if (err_m !== 1'b1) begin errors++; $display("FAIL uf_sticky got %0b want 1", err_m); end
    push[1] = push[1] + 1;
    step();
    checks++; if (valid_m !== 1'b1 || gidx_m !== 2'd1)
      begin errors++; $display("FAIL uf_issue got valid=%0b gidx=%0d want valid=1 gidx=1", valid_m, gidx_m); end
    reset_n = 1'b0;
    step();
    checks++; if (valid_m !== 1'b0) begin errors++; $display("FAIL rst_valid got %0b want 0", valid_m); end
    checks++; if (outst_m !== 8'd0) begin errors++; $display("FAIL rst_outst got %0d want 0", outst_m); end
    checks++; if (err_m !== 1'b0) begin errors++; $display("FAIL rst_err got %0b want 0", err_m); end
    for (int i = 0; i < 4; i++) push[i] = pop[i] + 1;
    reset_n = 1'b1;
    #1;
    checks++; if (rd_m !== 4'b0001) begin errors++; $display("FAIL rst_ptr_pop got %b want 0001", rd_m); end
    step();
    checks++; if (gidx_m !== 2'd0) begin errors++; $display("FAIL rst_ptr_gidx got %0d want 0", gidx_m); end
  endtask

  task automatic test_qos();
    logic [3:0] exp_rd;
    logic [1:0] exp_g;
`ifdef AXI_ARB_QOS_EN
    exp_rd = 4'b1000; exp_g = 2'd3;
`else
    exp_rd = 4'b0001; exp_g = 2'd0;
`endif
    do_reset();
    req_hipri = 4'b1000;
    for (int i = 0; i < 4; i++) push[i] = push[i] + 1;
    #1;
    checks++; if (rd_m !== exp_rd) begin errors++; $display("FAIL qos_pop got %b want %b", rd_m, exp_rd); end
    step();
    checks++; if (gidx_m !== exp_g) begin errors++; $display("FAIL qos_gidx got %0d want %0d", gidx_m, exp_g); end
  endtask

  initial begin
    reset_n = 1'b0; axi_axready = 1'b0; resp_done = 1'b0; rd_transfifo_full = 1'b0;
    req_hipri = '0; sel_c = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push[i] = 0;
      pop[i]  = 0;
      ent[i]  = '0;
    end
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_credit();
    test_underflow_reset();
    test_qos();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
